// File: rtl/pipe_pkg.sv
// Shared pipeline types for the fetch/decode boundary.
// Holds the decode bubble encoding and the fetch packet that the fetch
// queue stores and the decode stage consumes.
package pipe_pkg;

   localparam int XLEN = 32;

   // addi x0, x0, 0 -- the canonical RISC-V NOP used as a decode bubble
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
   } fetch_pkt_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Storage array for the fetch queue: DEPTH fetch packets with one
// synchronous write port and one asynchronous read port. Entries carry no
// reset; occupancy is tracked entirely by the pointer/count logic in the top.
module fetch_queue_mem
   import pipe_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  fetch_pkt_t    wdata,
   input  logic [AW-1:0] raddr,
   output fetch_pkt_t    rdata
);

   fetch_pkt_t mem_q [DEPTH];

   // Capture the incoming packet at the write pointer on a push.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue: circular FIFO decoupling fetch from decode.
// Head entry is presented to decode with a valid/ready handshake; fetch is
// throttled through enableF; a redirect from execute (PCSrcE) empties the
// queue in one cycle and drops that cycle's fetch.
// DATA_WIDTH must equal pipe_pkg::XLEN because entries use fetch_pkt_t.
// Optional build macro FETCH_QUEUE_PERF_EN adds saturating full/empty
// cycle counters exposed as full_cyclesQ and empty_cyclesQ.
module fetch_queue
   import pipe_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] instrF,
   input  logic [DATA_WIDTH-1:0] PCF,
   input  logic [DATA_WIDTH-1:0] PCPlus4F,
   input  logic                  validF,
   output logic                  enableF,
   input  logic                  PCSrcE,
   input  logic                  readyD,
   output logic                  validD,
   output logic [DATA_WIDTH-1:0] instrD,
   output logic [DATA_WIDTH-1:0] PCD,
   output logic [DATA_WIDTH-1:0] PCPlus4D
`ifdef FETCH_QUEUE_PERF_EN
   ,
   output logic [31:0]           full_cyclesQ,
   output logic [31:0]           empty_cyclesQ
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic          push, pop;
   fetch_pkt_t    wr_pkt, head_pkt;

   // Handshakes: both depend only on registered state plus the redirect, so
   // readyD never reaches enableF and validF never reaches validD.
   assign enableF = (count_q != FULL_CNT) && !PCSrcE;
   assign validD  = (count_q != '0);
   assign push    = validF && enableF;
   assign pop     = validD && readyD && !PCSrcE;

   assign wr_pkt = '{instr: instrF, pc: PCF, pc_plus4: PCPlus4F};

   fetch_queue_mem #(
      .DEPTH(DEPTH)
   ) u_mem (
      .clk  (clk),
      .we   (push),
      .waddr(wr_ptr_q),
      .wdata(wr_pkt),
      .raddr(rd_ptr_q),
      .rdata(head_pkt)
   );

   // Next pointer/count state; a redirect overrides any push or pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (PCSrcE) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (pop && !push) count_d = count_q - CW'(1);
      end
   end

   // Occupancy state register with asynchronous clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Present the head entry, or a NOP bubble when the queue is empty.
   always_comb begin
      instrD   = NOP_INSTR;
      PCD      = '0;
      PCPlus4D = '0;
      if (validD) begin
         instrD   = head_pkt.instr;
         PCD      = head_pkt.pc;
         PCPlus4D = head_pkt.pc_plus4;
      end
   end

`ifdef FETCH_QUEUE_PERF_EN
   logic [31:0] full_cycles_q;
   logic [31:0] empty_cycles_q;

   // Saturating full/empty occupancy counters; redirect cycles are not counted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         full_cycles_q  <= '0;
         empty_cycles_q <= '0;
      end else if (!PCSrcE) begin
         if ((count_q == FULL_CNT) && (full_cycles_q != '1)) begin
            full_cycles_q <= full_cycles_q + 32'd1;
         end
         if ((count_q == '0) && (empty_cycles_q != '1)) begin
            empty_cycles_q <= empty_cycles_q + 32'd1;
         end
      end
   end

   assign full_cyclesQ  = full_cycles_q;
   assign empty_cyclesQ = empty_cycles_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, hand-written reset and
// wrap sequences, and randomized traffic against a queue-based model.
module tb_fetch_queue;
   import pipe_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instrF, PCF, PCPlus4F;
   logic        validF, PCSrcE, readyD;
   logic        enableF, validD;
   logic [31:0] instrD, PCD, PCPlus4D;
`ifdef FETCH_QUEUE_PERF_EN
   logic [31:0] full_cyclesQ, empty_cyclesQ;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_queue #(
      .DATA_WIDTH(32),
      .DEPTH     (DEPTH)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .instrF  (instrF),
      .PCF     (PCF),
      .PCPlus4F(PCPlus4F),
      .validF  (validF),
      .enableF (enableF),
      .PCSrcE  (PCSrcE),
      .readyD  (readyD),
      .validD  (validD),
      .instrD  (instrD),
      .PCD     (PCD),
      .PCPlus4D(PCPlus4D)
`ifdef FETCH_QUEUE_PERF_EN
      ,
      .full_cyclesQ (full_cyclesQ),
      .empty_cyclesQ(empty_cyclesQ)
`endif
   );

   typedef struct {
      logic        vf;
      logic        rd;
      logic        fl;
      logic [31:0] pc;
      logic        ev;
      logic        een;
      logic [31:0] epc;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] mq[$];

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return pc ^ 32'h5A00_0033;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk_head(input string tag, input logic ev, input logic een, input logic [31:0] epc);
      chk({tag, " validD"},   32'(validD),  32'(ev));
      chk({tag, " enableF"},  32'(enableF), 32'(een));
      chk({tag, " PCD"},      PCD,          ev ? epc : 32'h0);
      chk({tag, " instrD"},   instrD,       ev ? instr_of(epc) : NOP_INSTR);
      chk({tag, " PCPlus4D"}, PCPlus4D,     ev ? epc + 32'd4 : 32'h0);
   endtask

   task automatic drive(input logic vf, input logic rd, input logic fl, input logic [31:0] pc);
      validF   = vf;
      readyD   = rd;
      PCSrcE   = fl;
      PCF      = pc;
      instrF   = instr_of(pc);
      PCPlus4F = pc + 32'd4;
   endtask

   // One cycle against the model: outputs checked before the edge, then the
   // model applies the queue rules (flush clears; otherwise pop head if any
   // and decode ready, append if fetch valid and the queue was not full).
   task automatic mstep(input string tag, input logic vf, input logic rd, input logic fl, input logic [31:0] pc);
      bit do_pop, do_push;
      @(negedge clk);
      drive(vf, rd, fl, pc);
      #1;
      chk_head(tag, mq.size() != 0, (mq.size() != DEPTH) && !fl,
               (mq.size() != 0) ? mq[0] : 32'h0);
      if (fl) begin
         mq.delete();
      end else begin
         do_pop  = (mq.size() != 0) && rd;
         do_push = vf && (mq.size() != DEPTH);
         if (do_pop)  void'(mq.pop_front());
         if (do_push) mq.push_back(pc);
      end
      @(posedge clk);
   endtask

   initial begin
      int sent;
      logic pushed;

      // Reset then idle
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      @(negedge clk);
      #1 chk_head("in_reset", 1'b0, 1'b1, 32'h0);
      reset = 1'b1;
      @(negedge clk);
      #1 chk_head("idle", 1'b0, 1'b1, 32'h0);

      // Directed table: post-edge expectations with the row's inputs still applied
      vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'h00}); // stream
      vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h04, 1'b1, 1'b1, 32'h04});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h08, 1'b1, 1'b1, 32'h08});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 32'h00});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 1'b1, 32'h10}); // fill
      vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h14, 1'b1, 1'b1, 32'h10});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h18, 1'b1, 1'b1, 32'h10});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h1C, 1'b1, 1'b0, 32'h10});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h20, 1'b1, 1'b0, 32'h10}); // 5th dropped
      vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'h14}); // drain
      vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'h18});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'h1C});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 32'h00});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h30, 1'b1, 1'b1, 32'h30}); // flush
      vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h34, 1'b1, 1'b1, 32'h30});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h38, 1'b1, 1'b1, 32'h30});
      vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h3C, 1'b0, 1'b0, 32'h00});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h100, 1'b1, 1'b1, 32'h100});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 32'h00});

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].vf, vecs[i].rd, vecs[i].fl, vecs[i].pc);
         @(posedge clk);
         #1 chk_head($sformatf("vec%0d", i), vecs[i].ev, vecs[i].een, vecs[i].epc);
      end

      // Async reset between edges with two entries queued
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 32'h200);
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 32'h204);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      #1 chk_head("pre_arst", 1'b1, 1'b1, 32'h200);
      #1 reset = 1'b0;
      #1 chk_head("arst", 1'b0, 1'b1, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      mq.delete();

      // Wrap-around: 10 instructions with alternating decode stalls
      sent = 0;
      for (int c = 0; c < 60 && (sent < 10 || mq.size() != 0); c++) begin
         pushed = (sent < 10) && (mq.size() != DEPTH);
         mstep("wrap", sent < 10, c[0], 1'b0, 32'h400 + 32'(sent) * 32'd4);
         if (pushed) sent++;
      end
      chk("wrap sent", 32'(sent), 32'd10);
      #1 chk("wrap drained validD", 32'(validD), 32'd0);

      // Randomized traffic including occasional redirects
      for (int c = 0; c < 400; c++) begin
         mstep("rnd", ($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 20) == 0,
               $urandom & 32'hFFFF_FFFC);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
